rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port between two writeback requesters, for example the ALU path (req0) and the load/memory path (req1), using round-robin arbitration with a valid/ready handshake. Accepted writes pass through one registered output stage that drives the register file's write-enable, write-address and write-data inputs. The block also flags in-flight writes that register-file reads would otherwise miss, so the decode stage can forward `rf_wdata`. It sits between the writeback stage and the register file.

## Interface
- DATA_W, 16, width of write data; must match the register file.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- freeze  in  1  pipeline stall; while 1 no new request is granted.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  5  destination register of requester 0.
- req0_data  in  DATA_W  write data of requester 0.
- req0_ready  out  1  requester 0's write is accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_ready  same as above, for requester 1.
- raddr_1  in  5  register-file read address 1, used for hazard compare.
- raddr_2  in  5  register-file read address 2, used for hazard compare.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- fwd_hit_1  out  1  1 when `rf_wdata` must replace read data 1 (combinational).
- fwd_hit_2  out  1  1 when `rf_wdata` must replace read data 2 (combinational).

## Operation
- State:
  - round-robin pointer `prio`, where 0 means req0 is favoured;
  - output stage {rf_we, rf_waddr, rf_wdata}.
- The register file never back-pressures, so the output stage is reloaded every cycle.
- Grant logic, evaluated combinationally each cycle:
  - freeze=1: both ready=0.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester selected by `prio` gets ready=1; the other gets ready=0.
  - Neither valid: both ready=0.
- A handshake (valid & ready) is the only event that transfers a write.
- Requesters must hold valid, addr and data stable until ready is seen.
- `prio` update:
  - On a grant to requester k, `prio` becomes 1-k, so the other requester is favoured next.
  - With no grant, `prio` holds.
  - Starvation bound: a continuously valid requester waits at most 1 cycle while the other is also valid, excluding freeze cycles.
- Output stage loading:
  - On a grant with addr != 0: rf_we=1, rf_waddr=addr, rf_wdata=data.
  - On a grant with addr == 0: the request is consumed (ready=1, `prio` updates) but rf_we=0, because x0 is constant zero.
  - With no grant: rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Forwarding:
  - fwd_hit_1 = rf_we & (rf_waddr == raddr_1) & (raddr_1 != 0).
  - fwd_hit_2 is the same using raddr_2.
- Reset (rst=1 at an edge):
  - `prio`=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - Any pending request is neither accepted nor lost; it is granted after reset releases.
- While rst=1, ready outputs are forced to 0.
- Identical addresses from both requesters are serialized in grant order; the later grant wins in the register file.

## Timing
- Acceptance at edge t produces rf_we=1 during cycle t+1 (1-cycle latency).
- The register file updates at edge t+2.
- Reads return the new value from cycle t+2 onward.
- During cycle t+1, a read of the same address sees the old value from the array; fwd_hit asserts for that cycle.
- Throughput: one write per cycle, sustained indefinitely with alternating grants when both requesters are valid.
- freeze affects grants only:
  - an already-registered write still completes (rf_we stays 1 in the cycle after the last grant);
  - rf_we=0 from the next cycle while freeze holds.
- Reset is synchronous: asserting rst mid-transfer clears rf_we at the next edge, so the in-flight write is dropped.

## Test plan
- Reset: hold rst=1 with both requesters valid for 3 cycles -> ready=0, rf_we=0, all outputs 0; after release, req0 is granted first (`prio`=0).
- Single requester: req0 writes addr 5, data 0x1234 -> req0_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; the cycle after, rf_we=0.
- Contention: both requesters valid for 6 cycles with distinct addresses -> grants alternate 0,1,0,1,0,1; rf_we stays 1 in every output cycle.
- x0 write: req1 writes addr 0, data 0xFFFF -> req1_ready=1, rf_we stays 0, and the next contention favours req0.
- Forwarding: grant addr 7, then in the following cycle set raddr_1=7, raddr_2=0 -> fwd_hit_1=1, fwd_hit_2=0; one cycle later both are 0.
- Freeze and reset: freeze=1 for 3 cycles with req0 valid -> ready=0 and rf_we=0 after the draining cycle; on release, req0 is accepted. Assert rst in the cycle after a grant -> rf_we=0 at the next edge.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter that shares the single register-file write port
// between two writeback requesters. Accepted writes go through one
// registered stage that drives the register file. Writes in flight are
// flagged to the decode stage so it can forward rf_wdata.

module rf_write_arbiter #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              req0_valid,
   input  logic [4:0]        req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [4:0]        req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic [4:0]        raddr_1,
   input  logic [4:0]        raddr_2,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              fwd_hit_1,
   output logic              fwd_hit_2
);

   // Round-robin pointer: 0 favours req0, 1 favours req1.
   logic              prio;

   // Grant signals and the write they select.
   logic              grant0;
   logic              grant1;
   logic              any_grant;
   logic [4:0]        sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Grant decision. Reset and freeze suppress every grant; a lone valid
   // requester always wins, and on contention prio picks the winner.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst && !freeze) begin
         grant0 = req0_valid && (!req1_valid || (prio == 1'b0));
         grant1 = req1_valid && (!req0_valid || (prio == 1'b1));
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign any_grant  = grant0 | grant1;

   // Select the granted requester's write for the output stage.
   always_comb begin
      sel_addr = req0_addr;
      sel_data = req0_data;
      if (grant1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
   end

   // Pointer update and output stage load. The register file never stalls,
   // so the stage is reloaded every cycle; writes to x0 are consumed but
   // never raise rf_we, since x0 is hardwired to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio     <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= '0;
      end else if (any_grant) begin
         prio  <= grant0;
         rf_we <= (sel_addr != 5'd0);
         if (sel_addr != 5'd0) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
         end
      end else begin
         rf_we <= 1'b0;
      end
   end

   // Forwarding flags: the staged write is not yet in the array, so a read
   // of the same non-zero register must take rf_wdata instead.
   always_comb begin
      fwd_hit_1 = rf_we && (rf_waddr == raddr_1) && (raddr_1 != 5'd0);
      fwd_hit_2 = rf_we && (rf_waddr == raddr_2) && (raddr_2 != 5'd0);
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed testbench for rf_write_arbiter with hand-computed expectations.

module tb_rf_write_arbiter;

   localparam int DATA_W = 16;

   logic              clk;
   logic              rst;
   logic              freeze;
   logic              req0_valid;
   logic [4:0]        req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [4:0]        req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic [4:0]        raddr_1;
   logic [4:0]        raddr_2;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              fwd_hit_1;
   logic              fwd_hit_2;

   int compared   = 0;
   int mismatched = 0;

   rf_write_arbiter #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .raddr_1    (raddr_1),
      .raddr_2    (raddr_2),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .fwd_hit_1  (fwd_hit_1),
      .fwd_hit_2  (fwd_hit_2)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive both requesters, then let combinational outputs settle.
   task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [DATA_W-1:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [DATA_W-1:0] d1);
      req0_valid = v0;
      req0_addr  = a0;
      req0_data  = d0;
      req1_valid = v1;
      req1_addr  = a1;
      req1_data  = d1;
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the whole output stage at once.
   task automatic checkStage(input string tag, input logic we, input logic [4:0] wa,
                             input logic [DATA_W-1:0] wd);
      checkOutput({tag, "_we"}, 32'(rf_we), 32'(we));
      checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'(wa));
      checkOutput({tag, "_wdata"}, 32'(rf_wdata), 32'(wd));
   endtask

   initial begin
      logic [4:0]        ea;
      logic [DATA_W-1:0] ed;
      rst     = 1'b1;
      freeze  = 1'b0;
      raddr_1 = 5'd0;
      raddr_2 = 5'd0;
      applyStimulus(1'b1, 5'd3, 16'hAAAA, 1'b1, 5'd4, 16'hBBBB);

      // Reset held three cycles with both requesters valid.
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
         checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
         checkStage("rst", 1'b0, 5'd0, 16'h0000);
         checkOutput("rst_fwd1", 32'(fwd_hit_1), 32'd0);
      end

      // Release: req0 favoured first, then req1 is served.
      rst = 1'b0;
      #1;
      checkOutput("rel_ready0", 32'(req0_ready), 32'd1);
      checkOutput("rel_ready1", 32'(req1_ready), 32'd0);
      tick();
      checkStage("rel_out0", 1'b1, 5'd3, 16'hAAAA);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd4, 16'hBBBB);
      checkOutput("rel_ready1b", 32'(req1_ready), 32'd1);
      tick();
      checkStage("rel_out1", 1'b1, 5'd4, 16'hBBBB);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
      checkOutput("idle_ready0", 32'(req0_ready), 32'd0);
      checkOutput("idle_ready1", 32'(req1_ready), 32'd0);
      tick();
      checkOutput("idle_we", 32'(rf_we), 32'd0);

      // Single requester: req0 writes x5.
      applyStimulus(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0000);
      checkOutput("single_ready0", 32'(req0_ready), 32'd1);
      tick();
      checkStage("single_out", 1'b1, 5'd5, 16'h1234);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
      tick();
      checkOutput("single_we_off", 32'(rf_we), 32'd0);

      // x0 write from req1: consumed, but never enables the write.
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 16'hFFFF);
      checkOutput("x0_ready1", 32'(req1_ready), 32'd1);
      tick();
      checkOutput("x0_we", 32'(rf_we), 32'd0);

      // Contention for six cycles: grants alternate 0,1,0,1,0,1.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 5'(8 + i / 2), 16'h1000 + 16'(8 + i / 2),
                       1'b1, 5'(16 + i / 2), 16'h2000 + 16'(16 + i / 2));
         checkOutput($sformatf("cont%0d_ready0", i), 32'(req0_ready), 32'((i % 2) == 0));
         checkOutput($sformatf("cont%0d_ready1", i), 32'(req1_ready), 32'((i % 2) == 1));
         ea = ((i % 2) == 0) ? 5'(8 + i / 2) : 5'(16 + i / 2);
         ed = ((i % 2) == 0) ? 16'h1000 + 16'(8 + i / 2) : 16'h2000 + 16'(16 + i / 2);
         tick();
         checkStage($sformatf("cont%0d", i), 1'b1, ea, ed);
      end

      // Forwarding: write x7, then read x7 on port 1 and x0 on port 2.
      applyStimulus(1'b1, 5'd7, 16'h7777, 1'b0, 5'd0, 16'h0000);
      checkOutput("fwd_ready0", 32'(req0_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
      raddr_1 = 5'd7;
      raddr_2 = 5'd0;
      #1;
      checkOutput("fwd_hit1", 32'(fwd_hit_1), 32'd1);
      checkOutput("fwd_hit2", 32'(fwd_hit_2), 32'd0);
      raddr_2 = 5'd6;
      #1;
      checkOutput("fwd_hit2_other", 32'(fwd_hit_2), 32'd0);
      raddr_2 = 5'd7;
      #1;
      checkOutput("fwd_hit2_same", 32'(fwd_hit_2), 32'd1);
      raddr_2 = 5'd0;
      tick();
      checkOutput("fwd_hit1_late", 32'(fwd_hit_1), 32'd0);
      checkOutput("fwd_hit2_late", 32'(fwd_hit_2), 32'd0);
      raddr_1 = 5'd0;

      // Freeze: last grant drains, then no grants for three cycles.
      applyStimulus(1'b1, 5'd12, 16'hC0C0, 1'b0, 5'd0, 16'h0000);
      checkOutput("frz_pre_ready0", 32'(req0_ready), 32'd1);
      tick();
      freeze = 1'b1;
      applyStimulus(1'b1, 5'd13, 16'hD0D0, 1'b0, 5'd0, 16'h0000);
      checkStage("frz_drain", 1'b1, 5'd12, 16'hC0C0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("frz%0d_ready0", i), 32'(req0_ready), 32'd0);
         tick();
         checkOutput($sformatf("frz%0d_we", i), 32'(rf_we), 32'd0);
      end
      freeze = 1'b0;
      #1;
      checkOutput("frz_rel_ready0", 32'(req0_ready), 32'd1);
      tick();
      checkStage("frz_rel_out", 1'b1, 5'd13, 16'hD0D0);

      // Reset right after a grant drops the in-flight write; the pending
      // request survives and is granted after release.
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd20, 16'h1414);
      checkOutput("rst2_ready1", 32'(req1_ready), 32'd1);
      tick();
      checkOutput("rst2_we_pre", 32'(rf_we), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b1, 5'd21, 16'h1515, 1'b0, 5'd0, 16'h0000);
      checkOutput("rst2_ready0_forced", 32'(req0_ready), 32'd0);
      tick();
      checkStage("rst2_cleared", 1'b0, 5'd0, 16'h0000);
      rst = 1'b0;
      #1;
      checkOutput("rst2_ready0_after", 32'(req0_ready), 32'd1);
      tick();
      checkStage("rst2_out", 1'b1, 5'd21, 16'h1515);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
